// File: rtl/key_io_pkg.sv
// Shared constants for the key I/O peripheral: register map and default sizing.
package key_io_pkg;

  // Register select values seen on reg_addr
  localparam logic REG_LEVEL = 1'b0;
  localparam logic REG_EVENT = 1'b1;

  // Default sizing
  localparam int NKEYS_DEFAULT           = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 3;

endpackage : key_io_pkg

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser on the inverted pin, then a counter-based
// debouncer. stable_o is the accepted level (1 = pressed). rise_o pulses for
// one cycle, combinationally from registered state only, in the cycle whose
// closing edge moves stable from 0 to 1.
module key_debounce
  import key_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser; the pin is inverted so that pressed reads as 1
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronised value disagrees with stable;
  // any agreement restarts the count, so short glitches never get accepted
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state register; reset discards any partial count
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;

endmodule : key_debounce

// File: rtl/key_io.sv
// Memory-mapped push-button peripheral. Each key is synchronised and
// debounced; the CPU sees a read-only LEVEL register (debounced state) and a
// sticky EVENT register (press captures, write-1-to-clear). A press detected
// in the same cycle as a clear of that bit wins, so no press is ever lost.
// Bus: sel qualifies both reads and writes; reads are combinational and have
// no side effects, writes take effect on the next rising clk edge.
module key_io
  import key_io_pkg::*;
#(
  parameter int NKEYS           = NKEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic             sel,
  input  logic             we,
  input  logic             reg_addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             event_pending
);

  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] set_now;
  logic [NKEYS-1:0] event_q, event_d;
  logic             event_wr;
  logic             unused_wdata;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk),
      .reset_i (reset),
      .key_n_i (key_n[i]),
      .stable_o(stable[i]),
      .rise_o  (set_now[i])
    );
  end

  assign event_wr = sel & we & (reg_addr == REG_EVENT);

  // Bits of wdata above NKEYS have no register behind them
  assign unused_wdata = ^wdata;

  // Next EVENT: clear the written ones, then OR in this cycle's presses
  always_comb begin
    event_d = event_q | set_now;
    if (event_wr) begin
      event_d = (event_q & ~wdata[NKEYS-1:0]) | set_now;
    end
  end

  // EVENT register
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= '0;
    end else begin
      event_q <= event_d;
    end
  end

  // Read mux; deselected reads return zero, upper bits always zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      if (reg_addr == REG_LEVEL) begin
        rdata[NKEYS-1:0] = stable;
      end else begin
        rdata[NKEYS-1:0] = event_q;
      end
    end
  end

  assign event_pending = |event_q;

endmodule : key_io

// File: tb/tb_key_io.sv
// Bench for key_io: every bus cycle pushes its expected {event_pending, rdata}
// into a queue; a monitor pops and compares shortly after each falling edge.
// Expectations come either from hand-derived constants (directed part) or a
// window-based reference model (random part).
module tb_key_io;

  localparam int NK = 4;
  localparam int DB = 3;

  logic          clk;
  logic          reset;
  logic [NK-1:0] key_n;
  logic          sel;
  logic          we;
  logic          reg_addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          event_pending;

  key_io #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .sel          (sel),
    .we           (we),
    .reg_addr     (reg_addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .event_pending(event_pending)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // ---------------- reference model ----------------
  // hist[k][j] = pressed value of key k sampled j+1 edges ago. A key's level
  // flips at an edge when the samples taken 2..DB+1 edges earlier all
  // disagree with the current level.
  logic [DB:0]   hist [NK];
  logic [NK-1:0] m_level;
  logic [NK-1:0] m_ev;

  function automatic logic [31:0] model_rdata(input logic s, input logic a);
    logic [31:0] r;
    r = '0;
    if (s) r[NK-1:0] = a ? m_ev : m_level;
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic [NK-1:0] kn,
                            input logic s, input logic w, input logic a,
                            input logic [31:0] wd);
    logic [NK-1:0] presses;
    logic          all_diff;
    if (rst) begin
      for (int k = 0; k < NK; k++) hist[k] = '0;
      m_level = '0;
      m_ev    = '0;
    end else begin
      presses = '0;
      for (int k = 0; k < NK; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++) begin
          if (hist[k][j] == m_level[k]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (!m_level[k]) presses[k] = 1'b1;
          m_level[k] = ~m_level[k];
        end
      end
      if (s && w && a) m_ev = (m_ev & ~wd[NK-1:0]) | presses;
      else             m_ev = m_ev | presses;
      for (int k = 0; k < NK; k++) hist[k] = {hist[k][DB-1:0], ~kn[k]};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [NK-1:0] kn, input logic s,
                       input logic w, input logic a, input logic [31:0] wd);
    @(negedge clk);
    reset    = rst;
    key_n    = kn;
    sel      = s;
    we       = w;
    reg_addr = a;
    wdata    = wd;
  endtask

  // Bus cycle checked against the reference model
  task automatic bus(input logic rst, input logic [NK-1:0] kn, input logic s,
                     input logic w, input logic a, input logic [31:0] wd);
    drive(rst, kn, s, w, a, wd);
    exp_q.push_back({|m_ev, model_rdata(s, a)});
    model_edge(rst, kn, s, w, a, wd);
  endtask

  // Bus cycle checked against hand-derived constants (model still advances)
  task automatic bus_exp(input logic rst, input logic [NK-1:0] kn, input logic s,
                         input logic w, input logic a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ep);
    drive(rst, kn, s, w, a, wd);
    exp_q.push_back({ep, er});
    model_edge(rst, kn, s, w, a, wd);
  endtask

  task automatic rdc(input logic [NK-1:0] kn, input logic a,
                     input logic [31:0] er, input logic ep);
    bus_exp(1'b0, kn, 1'b1, 1'b0, a, 32'h0, er, ep);
  endtask

  task automatic rdm(input logic [NK-1:0] kn, input logic a);
    bus(1'b0, kn, 1'b1, 1'b0, a, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e[31:0]) begin
        errors++;
        $display("FAIL rdata t=%0t sel=%0b addr=%0b: got %h expected %h",
                 $time, sel, reg_addr, rdata, e[31:0]);
      end
      checks++;
      if (event_pending !== e[32]) begin
        errors++;
        $display("FAIL event_pending t=%0t: got %0b expected %0b",
                 $time, event_pending, e[32]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NK-1:0] kn;
    logic          rst, s, w, a;
    int            waited;

    reset = 1'b1; key_n = 4'hF; sel = 1'b0; we = 1'b0; reg_addr = 1'b0; wdata = '0;
    for (int k = 0; k < NK; k++) hist[k] = '0;
    m_level = '0;
    m_ev    = '0;

    // Reset held, all keys released
    bus_exp(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus_exp(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

    // Clean press of key 0: visible after the 5th edge, not before
    rdc(4'hE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) rdc(4'hE, 1'b0, 32'h0, 1'b0);
    rdc(4'hE, 1'b0, 32'h1, 1'b1);
    rdc(4'hE, 1'b1, 32'h1, 1'b1);

    // Two-cycle glitch on key 1 is rejected
    rdc(4'hC, 1'b0, 32'h1, 1'b1);
    rdc(4'hC, 1'b1, 32'h1, 1'b1);
    for (int i = 0; i < 6; i++) rdc(4'hE, 1'b0, 32'h1, 1'b1);
    rdc(4'hE, 1'b1, 32'h1, 1'b1);

    // Press key 2 -> EVENT = 0101
    rdc(4'hA, 1'b0, 32'h1, 1'b1);
    for (int i = 0; i < 4; i++) rdc(4'hA, 1'b0, 32'h1, 1'b1);
    rdc(4'hA, 1'b0, 32'h5, 1'b1);
    rdc(4'hA, 1'b1, 32'h5, 1'b1);

    // W1C bit 0, then a write to LEVEL changes nothing
    bus_exp(1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 32'h1, 32'h5, 1'b1);
    rdc(4'hA, 1'b1, 32'h4, 1'b1);
    bus_exp(1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 32'h0, 32'h5, 1'b1);
    rdc(4'hA, 1'b1, 32'h4, 1'b1);
    rdc(4'hA, 1'b0, 32'h5, 1'b1);

    // Clear bit 2, release key 2 (no event), re-press with a clear on the rising edge
    bus_exp(1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 32'h4, 32'h4, 1'b1);
    rdc(4'hA, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) rdm(4'hE, 1'b0);
    rdc(4'hE, 1'b0, 32'h1, 1'b0);
    rdc(4'hE, 1'b1, 32'h0, 1'b0);
    rdc(4'hA, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) rdc(4'hA, 1'b1, 32'h0, 1'b0);
    bus_exp(1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 32'h4, 32'h0, 1'b0);
    rdc(4'hA, 1'b1, 32'h4, 1'b1);
    rdc(4'hA, 1'b0, 32'h5, 1'b1);

    // Release key 0: LEVEL drops after the same latency, EVENT unchanged
    rdc(4'hB, 1'b0, 32'h5, 1'b1);
    for (int i = 0; i < 4; i++) rdc(4'hB, 1'b0, 32'h5, 1'b1);
    rdc(4'hB, 1'b0, 32'h4, 1'b1);
    rdc(4'hB, 1'b1, 32'h4, 1'b1);

    // Deselected: reads zero, writes ignored
    bus_exp(1'b0, 4'hB, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    bus_exp(1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    rdc(4'hB, 1'b1, 32'h4, 1'b1);

    // Key 2 held through reset comes back as a fresh press
    bus_exp(1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4, 1'b1);
    bus_exp(1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    rdc(4'hB, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) rdc(4'hB, 1'b0, 32'h0, 1'b0);
    rdc(4'hB, 1'b0, 32'h4, 1'b1);
    rdc(4'hB, 1'b1, 32'h4, 1'b1);

    // Reset in the middle of key 1's debounce: partial count is discarded
    for (int i = 0; i < 3; i++) rdc(4'h9, 1'b0, 32'h4, 1'b1);
    bus_exp(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4, 1'b1);
    bus_exp(1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) rdm(4'hB, 1'b0);
    rdc(4'hB, 1'b0, 32'h4, 1'b1);
    rdc(4'hB, 1'b1, 32'h4, 1'b1);

    // Random traffic against the reference model
    kn = 4'hB;
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 5) == 0) kn[k] = ~kn[k];
      end
      rst = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 3) == 0);
      a   = 1'($urandom_range(0, 1));
      bus(rst, kn, s, w, a, $urandom());
    end

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_key_io
